// File: rtl/csr_exec_pkg.sv
// rtl/csr_exec_pkg.sv - shared types for the CSR execution unit
// Contents: CSR op encoding, FSM state encoding, issue entry record.
package csr_exec_pkg;

  localparam int CSR_XLEN       = 32;
  localparam int CSR_PREG_WIDTH = 7;
  localparam int CSR_ROB_WIDTH  = 6;
  localparam int CSR_ADDR_WIDTH = 12;

  // funct3 encodings; 3'b000 and 3'b100 are not CSR ops and decode as illegal
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } csr_state_e;

  typedef struct packed {
    csr_op_e                   op;
    logic [CSR_ADDR_WIDTH-1:0] csrid;
    logic [4:0]                imm;
    logic                      src_zero;
    logic [CSR_XLEN-1:0]       rdata;
    logic                      we;
    logic [CSR_PREG_WIDTH-1:0] rd;
    logic [CSR_ROB_WIDTH:0]    robidx;
  } csr_exec_entry_t;

endpackage

// File: rtl/rob_older_cmp.sv
// rtl/rob_older_cmp.sv - ROB age compare with direction bit
// Ports: a, b = {dir, idx} ROB ids; older = 1 when a is older than b.
module rob_older_cmp #(
  parameter int ROB_WIDTH = 6
) (
  input  logic [ROB_WIDTH:0] a,
  input  logic [ROB_WIDTH:0] b,
  output logic               older
);

  // Same direction bit: plain index order. Different direction: b has wrapped,
  // so the larger index is the older one.
  assign older = (a[ROB_WIDTH] == b[ROB_WIDTH]) ? (a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0])
                                                : (a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0]);

endmodule

// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - non-pipelined CSR read/modify/write execution unit
// Ports: issue_* from the CSR issue queue (ready = idle), redirect/redirect_idx
// flush by ROB age, csr_* to the CSR file (combinational read, one-cycle write
// strobe), wb_* valid/ready writeback of the old CSR value.
// Optional macro CSR_EXEC_PERF_EN adds perf_inst / perf_stall counters.
module csr_exec_unit
  import csr_exec_pkg::*;
#(
  parameter int XLEN       = CSR_XLEN,
  parameter int PREG_WIDTH = CSR_PREG_WIDTH,
  parameter int ROB_WIDTH  = CSR_ROB_WIDTH,
  parameter int CSR_ADDR_W = CSR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_en,
  input  logic [2:0]            issue_op,
  input  logic [CSR_ADDR_W-1:0] issue_csrid,
  input  logic [4:0]            issue_imm,
  input  logic                  issue_src_zero,
  input  logic [XLEN-1:0]       issue_rdata,
  input  logic                  issue_we,
  input  logic [PREG_WIDTH-1:0] issue_rd,
  input  logic [ROB_WIDTH:0]    issue_robidx,
  output logic                  ready,
  input  logic                  redirect,
  input  logic [ROB_WIDTH:0]    redirect_idx,
  output logic [CSR_ADDR_W-1:0] csr_raddr,
  input  logic [XLEN-1:0]       csr_rdata,
  input  logic                  csr_illegal,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_we,
  output logic [PREG_WIDTH-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic [ROB_WIDTH:0]    wb_robidx,
  output logic                  wb_exception
`ifdef CSR_EXEC_PERF_EN
  ,
  output logic [31:0]           perf_inst,
  output logic [31:0]           perf_stall
`endif
);

  csr_state_e      state_q, state_d;
  csr_exec_entry_t entry_q, entry_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_we_q, wb_we_d;
  logic            wb_exc_q, wb_exc_d;

  logic            entry_older;
  logic            flush;
  logic            write_en;
  logic            illegal;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;

  rob_older_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_age (
    .a     (entry_q.robidx),
    .b     (redirect_idx),
    .older (entry_older)
  );

  // Anything at or younger than the redirect boundary is squashed.
  assign flush = redirect & ~entry_older;

  // op[1] set means set/clear; those never write when the source is x0/zimm 0.
  assign write_en = ~(entry_q.op[1] & entry_q.src_zero);
  assign operand  = entry_q.op[2] ? {{(XLEN-5){1'b0}}, entry_q.imm} : entry_q.rdata;
  assign illegal  = (entry_q.op[1:0] == 2'b00) | csr_illegal |
                    (write_en & (entry_q.csrid[CSR_ADDR_W-1 -: 2] == 2'b11));

  always_comb begin
    new_val = '0;
    case (entry_q.op)
      CSR_RW, CSR_RWI: new_val = operand;
      CSR_RS, CSR_RSI: new_val = csr_rdata | operand;
      CSR_RC, CSR_RCI: new_val = csr_rdata & ~operand;
      default:         new_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    wb_data_d = wb_data_q;
    wb_we_d   = wb_we_q;
    wb_exc_d  = wb_exc_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_en && !redirect) begin
          entry_d = '{op:       csr_op_e'(issue_op),
                      csrid:    issue_csrid,
                      imm:      issue_imm,
                      src_zero: issue_src_zero,
                      rdata:    issue_rdata,
                      we:       issue_we,
                      rd:       issue_rd,
                      robidx:   issue_robidx};
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          wb_data_d = csr_rdata;
          wb_exc_d  = illegal;
          wb_we_d   = entry_q.we & ~illegal;
          state_d   = ST_WB;
        end
      end
      ST_WB: begin
        if (flush || wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      entry_q   <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      wb_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      wb_exc_q  <= wb_exc_d;
    end
  end

  assign ready        = (state_q == ST_IDLE);
  assign csr_raddr    = entry_q.csrid;
  assign csr_we       = (state_q == ST_EXEC) & write_en & ~illegal & ~flush;
  assign csr_waddr    = entry_q.csrid;
  assign csr_wdata    = new_val;
  assign wb_valid     = (state_q == ST_WB);
  assign wb_we        = wb_we_q;
  assign wb_rd        = entry_q.rd;
  assign wb_data      = wb_data_q;
  assign wb_robidx    = entry_q.robidx;
  assign wb_exception = wb_exc_q;

`ifdef CSR_EXEC_PERF_EN
  logic [31:0] perf_inst_q, perf_inst_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_inst_d  = perf_inst_q;
    perf_stall_d = perf_stall_q;
    if (state_q == ST_WB && wb_ready && !flush) perf_inst_d  = perf_inst_q + 32'd1;
    if (state_q == ST_WB && !wb_ready)          perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_inst_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_inst_q  <= perf_inst_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_inst  = perf_inst_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_csr_exec_unit.sv
// tb/tb_csr_exec_unit.sv - self-checking bench for csr_exec_unit
module tb_csr_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_en = 1'b0;
  logic [2:0]  issue_op = '0;
  logic [11:0] issue_csrid = '0;
  logic [4:0]  issue_imm = '0;
  logic        issue_src_zero = 1'b0;
  logic [31:0] issue_rdata = '0;
  logic        issue_we = 1'b0;
  logic [6:0]  issue_rd = '0;
  logic [6:0]  issue_robidx = '0;
  logic        ready;
  logic        redirect = 1'b0;
  logic [6:0]  redirect_idx = '0;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata = '0;
  logic        csr_illegal = 1'b0;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic        wb_we;
  logic [6:0]  wb_rd;
  logic [31:0] wb_data;
  logic [6:0]  wb_robidx;
  logic        wb_exception;

  csr_exec_unit dut (
    .clk(clk), .rst(rst),
    .issue_en(issue_en), .issue_op(issue_op), .issue_csrid(issue_csrid),
    .issue_imm(issue_imm), .issue_src_zero(issue_src_zero), .issue_rdata(issue_rdata),
    .issue_we(issue_we), .issue_rd(issue_rd), .issue_robidx(issue_robidx),
    .ready(ready), .redirect(redirect), .redirect_idx(redirect_idx),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_robidx(wb_robidx), .wb_exception(wb_exception)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] csrid;
    logic [4:0]  imm;
    logic        sz;
    logic [31:0] rdata;
    logic        we;
    logic [6:0]  rd;
    logic [6:0]  rob;
    logic [31:0] old;
    logic        ill;
    logic        exp_csr_we;
    logic [31:0] exp_wdata;
    logic        exp_exc;
    logic        exp_wb_we;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [6:0]  rd;
    logic [6:0]  rob;
    logic        exc;
    int          issue_cyc;
    int          lat;
  } wb_exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } csrw_exp_t;

  wb_exp_t   wb_q[$];
  csrw_exp_t csrw_q[$];
  int        last_issue = 0;

  function automatic vec_t mk(input logic [2:0] op, input logic [11:0] csrid,
                              input logic [4:0] imm, input logic sz,
                              input logic [31:0] rdata, input logic we,
                              input logic [6:0] rd, input logic [6:0] rob,
                              input logic [31:0] old, input logic ill,
                              input logic ecw, input logic [31:0] ewd,
                              input logic eexc, input logic ewbwe);
    vec_t v;
    v.op = op; v.csrid = csrid; v.imm = imm; v.sz = sz; v.rdata = rdata;
    v.we = we; v.rd = rd; v.rob = rob; v.old = old; v.ill = ill;
    v.exp_csr_we = ecw; v.exp_wdata = ewd; v.exp_exc = eexc; v.exp_wb_we = ewbwe;
    return v;
  endfunction

  // Scoreboard: every CSR write strobe and every writeback handshake pops one expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (csr_we) begin
        chk("csr_we_expected", 64'(csrw_q.size() != 0), 64'd1);
        if (csrw_q.size() != 0) begin
          csrw_exp_t e;
          e = csrw_q.pop_front();
          chk("csr_waddr", 64'(csr_waddr), 64'(e.addr));
          chk("csr_raddr", 64'(csr_raddr), 64'(e.addr));
          chk("csr_wdata", 64'(csr_wdata), 64'(e.data));
        end
      end
      if (wb_valid && wb_ready) begin
        chk("wb_expected", 64'(wb_q.size() != 0), 64'd1);
        if (wb_q.size() != 0) begin
          wb_exp_t e;
          e = wb_q.pop_front();
          chk("wb_data", 64'(wb_data), 64'(e.data));
          chk("wb_we", 64'(wb_we), 64'(e.we));
          chk("wb_rd", 64'(wb_rd), 64'(e.rd));
          chk("wb_robidx", 64'(wb_robidx), 64'(e.rob));
          chk("wb_exception", 64'(wb_exception), 64'(e.exc));
          chk("wb_latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the capture edge (unit in EXEC).
  task automatic do_issue(input vec_t v, input logic push_wb, input int lat);
    int t;
    t = 0;
    while (!ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_before_issue", 64'(ready), 64'd1);
    csr_rdata = v.old; csr_illegal = v.ill;
    issue_op = v.op; issue_csrid = v.csrid; issue_imm = v.imm; issue_src_zero = v.sz;
    issue_rdata = v.rdata; issue_we = v.we; issue_rd = v.rd; issue_robidx = v.rob;
    issue_en = 1'b1;
    last_issue = cyc;
    if (v.exp_csr_we) csrw_q.push_back('{addr: v.csrid, data: v.exp_wdata});
    if (push_wb)
      wb_q.push_back('{data: v.old, we: v.exp_wb_we, rd: v.rd, rob: v.rob,
                       exc: v.exp_exc, issue_cyc: cyc, lat: lat});
    @(posedge clk); #1;
    issue_en = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((!ready || wb_q.size() != 0) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", 64'(t < 50), 64'd1);
  endtask

  vec_t vecs[15];
  vec_t v;
  logic [31:0] snap_data;

  initial begin
    //                op      csrid    imm    sz    rdata          we    rd     rob    old            ill   cwe   wdata          exc   wbwe
    vecs[0]  = mk(3'b001, 12'h340, 5'h00, 1'b0, 32'hAA,        1'b1, 7'h05, 7'h01, 32'h11,        1'b0, 1'b1, 32'hAA,        1'b0, 1'b1);
    vecs[1]  = mk(3'b110, 12'h300, 5'h00, 1'b1, 32'h0,         1'b1, 7'h06, 7'h02, 32'h8,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1);
    vecs[2]  = mk(3'b001, 12'hC00, 5'h00, 1'b0, 32'h5,         1'b1, 7'h07, 7'h03, 32'h77,        1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
    vecs[3]  = mk(3'b010, 12'h300, 5'h00, 1'b0, 32'hF0,        1'b1, 7'h08, 7'h04, 32'h0F,        1'b0, 1'b1, 32'hFF,        1'b0, 1'b1);
    vecs[4]  = mk(3'b011, 12'h300, 5'h00, 1'b0, 32'h0F,        1'b1, 7'h09, 7'h05, 32'hFF,        1'b0, 1'b1, 32'hF0,        1'b0, 1'b1);
    vecs[5]  = mk(3'b101, 12'h305, 5'h1F, 1'b0, 32'hDEAD,      1'b1, 7'h0A, 7'h06, 32'h100,       1'b0, 1'b1, 32'h1F,        1'b0, 1'b1);
    vecs[6]  = mk(3'b110, 12'h341, 5'h03, 1'b0, 32'h0,         1'b1, 7'h0B, 7'h07, 32'h10,        1'b0, 1'b1, 32'h13,        1'b0, 1'b1);
    vecs[7]  = mk(3'b111, 12'h341, 5'h01, 1'b0, 32'h0,         1'b1, 7'h0C, 7'h08, 32'h3,         1'b0, 1'b1, 32'h2,         1'b0, 1'b1);
    vecs[8]  = mk(3'b000, 12'h340, 5'h00, 1'b0, 32'h1,         1'b1, 7'h0D, 7'h09, 32'h4,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
    vecs[9]  = mk(3'b100, 12'h340, 5'h00, 1'b0, 32'h1,         1'b1, 7'h0E, 7'h0A, 32'h4,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
    vecs[10] = mk(3'b001, 12'h7C0, 5'h00, 1'b0, 32'h9,         1'b1, 7'h0F, 7'h0B, 32'h6,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0);
    vecs[11] = mk(3'b010, 12'hC01, 5'h00, 1'b1, 32'h0,         1'b1, 7'h10, 7'h0C, 32'h1234,      1'b0, 1'b0, 32'h0,         1'b0, 1'b1);
    vecs[12] = mk(3'b001, 12'h340, 5'h00, 1'b0, 32'h55,        1'b0, 7'h11, 7'h0D, 32'h22,        1'b0, 1'b1, 32'h55,        1'b0, 1'b0);
    vecs[13] = mk(3'b011, 12'hC02, 5'h00, 1'b0, 32'h1,         1'b1, 7'h12, 7'h0E, 32'h5,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
    vecs[14] = mk(3'b010, 12'h340, 5'h00, 1'b0, 32'hFFFF0000,  1'b1, 7'h13, 7'h4F, 32'h0000FFFF,  1'b0, 1'b1, 32'hFFFFFFFF,  1'b0, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_csr_we", 64'(csr_we), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    chk("reset_wb_exception", 64'(wb_exception), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors, wb_ready always high: writeback two cycles after issue
    wb_ready = 1'b1;
    foreach (vecs[i]) do_issue(vecs[i], 1'b1, 2);
    wait_drain();

    // Back-to-back throughput: one instruction every three cycles
    do_issue(vecs[0], 1'b1, 2);
    begin
      int c0;
      c0 = last_issue;
      do_issue(vecs[3], 1'b1, 2);
      chk("throughput", 64'(last_issue - c0), 64'd3);
    end
    wait_drain();

    // wb_ready stall for five cycles: writeback held stable, ready low
    wb_ready = 1'b0;
    v = mk(3'b001, 12'h340, 5'h0, 1'b0, 32'h1234, 1'b1, 7'h21, 7'h15, 32'hCAFE, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b1);
    do_issue(v, 1'b1, 7);
    @(posedge clk); #1;
    snap_data = wb_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wb_valid", 64'(wb_valid), 64'd1);
      chk("stall_ready", 64'(ready), 64'd0);
      chk("stall_wb_data", 64'(wb_data), 64'(snap_data));
      chk("stall_wb_rd", 64'(wb_rd), 64'h21);
      @(posedge clk); #1;
    end
    chk("stall_snap", 64'(snap_data), 64'hCAFE);
    wb_ready = 1'b1;
    wait_drain();

    // Redirect in EXEC on a younger entry: squashed
    v = mk(3'b001, 12'h340, 5'h0, 1'b0, 32'h99, 1'b1, 7'h22, 7'h05, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    do_issue(v, 1'b0, 0);
    redirect = 1'b1; redirect_idx = 7'h03;
    @(negedge clk);
    chk("flush_exec_csr_we", 64'(csr_we), 64'd0);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("flush_exec_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_exec_ready", 64'(ready), 64'd1);

    // Same redirect on an older entry: completes normally
    v = mk(3'b001, 12'h340, 5'h0, 1'b0, 32'h98, 1'b1, 7'h23, 7'h02, 32'h45, 1'b0, 1'b1, 32'h98, 1'b0, 1'b1);
    do_issue(v, 1'b1, 2);
    redirect = 1'b1; redirect_idx = 7'h03;
    @(negedge clk);
    chk("older_exec_csr_we", 64'(csr_we), 64'd1);
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_drain();

    // Flush in WB across the direction wrap: entry {1,1} is younger than {0,3}
    wb_ready = 1'b0;
    v = mk(3'b001, 12'h341, 5'h0, 1'b0, 32'h77, 1'b1, 7'h24, 7'h41, 32'h46, 1'b0, 1'b1, 32'h77, 1'b0, 1'b1);
    do_issue(v, 1'b0, 0);
    @(posedge clk); #1;
    chk("flush_wb_pre_valid", 64'(wb_valid), 64'd1);
    redirect = 1'b1; redirect_idx = 7'h03;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_wb_ready", 64'(ready), 64'd1);

    // Entry {1,5} is older than {0,3}: redirect in WB leaves it alone
    v = mk(3'b001, 12'h341, 5'h0, 1'b0, 32'h76, 1'b1, 7'h25, 7'h45, 32'h47, 1'b0, 1'b1, 32'h76, 1'b0, 1'b1);
    do_issue(v, 1'b1, 3);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_idx = 7'h03;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("older_wb_valid", 64'(wb_valid), 64'd1);
    wb_ready = 1'b1;
    wait_drain();

    // Issue with redirect in the same cycle is ignored
    issue_op = 3'b001; issue_csrid = 12'h340; issue_rdata = 32'h1; issue_en = 1'b1;
    redirect = 1'b1;
    @(posedge clk); #1;
    issue_en = 1'b0; redirect = 1'b0;
    chk("issue_redirect_ready", 64'(ready), 64'd1);
    @(negedge clk);
    chk("issue_redirect_csr_we", 64'(csr_we), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset in WB
    wb_ready = 1'b0;
    v = mk(3'b001, 12'h340, 5'h0, 1'b0, 32'h31, 1'b1, 7'h26, 7'h10, 32'h48, 1'b0, 1'b1, 32'h31, 1'b0, 1'b1);
    do_issue(v, 1'b0, 0);
    @(posedge clk); #1;
    chk("rst_pre_wb_valid", 64'(wb_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_csr_we", 64'(csr_we), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_ready", 64'(ready), 64'd1);
    chk("rst_after_wb_valid", 64'(wb_valid), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_empty", 64'(wb_q.size()), 64'd0);
    chk("csrw_queue_empty", 64'(csrw_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
